ps2_host_tx: RTL and testbench

Host-to-device transmitter for the PS/2 port, driving the open-drain clock and data lines toward the mouse. Lets the system send command bytes to the mouse, for example 0xFF (reset) and 0xF4 (enable data reporting), on the same bus the mouse controller receives on. Runs request-to-send inhibit, clocks out the frame on device-generated clock edges, checks the device acknowledge, and reports done or error. The top level maps `ps2_clk_oe`/`ps2_dat_oe` to tri-state drivers: the line is driven 0 when the enable is 1, and is high-Z otherwise.

---
 rtl/ps2_host_tx.sv | 144 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out a frame
// on device clock edges, then check the device ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int REQ_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       CLOCK,
   input  logic       reset,
   input  logic       send_cmd,
   input  logic [7:0] cmd_data,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int MAXC = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int WW   = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INH, S_REQ, S_SEND, S_ACK, S_DONE, S_ERR
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic           r_clk_s1;
   logic           r_clk_s2;
   logic           r_clk_prev;
   logic           r_dat_s1;
   logic           r_dat_s2;
   logic [7:0]     r_byte;
   logic [CW-1:0]  r_cnt;
   logic [WW-1:0]  r_wd;
   logic [3:0]     r_bit;
   logic           r_dat;
   logic           w_fall;
   logic           w_wd_exp;
   logic [10:0]    w_frame;
   logic [3:0]     w_bit_nx;

   assign w_fall   = r_clk_prev & ~r_clk_s2;
   assign w_wd_exp = (r_wd == WW'(TIMEOUT_CYCLES));
   assign w_frame  = {1'b1, 1'b1, ~^r_byte, r_byte};
   assign w_bit_nx = r_bit + 4'd1;

   // Idle bus lines are high, so the synchronisers reset to 1
   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_clk_prev <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
      end else begin
         r_clk_s1   <= ps2_clk_in;
         r_clk_s2   <= r_clk_s1;
         r_clk_prev <= r_clk_s2;
         r_dat_s1   <= ps2_dat_in;
         r_dat_s2   <= r_dat_s1;
      end
   end

   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (send_cmd) w_next = S_INH;
         S_INH:  if (r_cnt == CW'(INHIBIT_CYCLES - 1)) w_next = S_REQ;
         S_REQ:  if (r_cnt == CW'(REQ_CYCLES - 1)) w_next = S_SEND;
         S_SEND: begin
            if (w_wd_exp)                       w_next = S_ERR;
            else if (w_fall && r_bit == 4'd9)   w_next = S_ACK;
         end
         S_ACK: begin
            if (w_wd_exp)    w_next = S_ERR;
            else if (w_fall) w_next = r_dat_s2 ? S_ERR : S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         r_byte <= '0;
         r_cnt  <= '0;
         r_wd   <= '0;
         r_bit  <= '0;
         r_dat  <= 1'b0;
      end else begin
         if (r_state == S_IDLE && send_cmd)
            r_byte <= cmd_data;

         if (w_next != r_state)
            r_cnt <= '0;
         else if (r_state == S_INH || r_state == S_REQ)
            r_cnt <= r_cnt + CW'(1);

         // Watchdog runs only while the device owns the clock
         if (r_state == S_SEND || r_state == S_ACK)
            r_wd <= w_fall ? '0 : r_wd + WW'(1);
         else
            r_wd <= '0;

         if (r_state == S_REQ && w_next == S_SEND) begin
            r_bit <= '0;
            r_dat <= ~w_frame[0];
         end else if (r_state == S_SEND && w_fall && w_next == S_SEND) begin
            r_bit <= w_bit_nx;
            r_dat <= ~w_frame[w_bit_nx];
         end
      end
   end

   always_comb begin
      ps2_clk_oe = 1'b0;
      ps2_dat_oe = 1'b0;
      busy       = (r_state != S_IDLE);
      done       = 1'b0;
      error      = 1'b0;
      unique case (r_state)
         S_INH:  ps2_clk_oe = 1'b1;
         S_REQ: begin
            ps2_clk_oe = 1'b1;
            ps2_dat_oe = 1'b1;
         end
         S_SEND: ps2_dat_oe = r_dat;
         S_DONE: done = 1'b1;
         S_ERR:  error = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model
// clocking the frame and driving the ACK slot.
module tb_ps2_host_tx;

   localparam int INH = 20;
   localparam int REQ = 5;
   localparam int TO  = 300;
   localparam int HP  = 15;

   logic       clk;
   logic       reset;
   logic       send_cmd;
   logic [7:0] cmd_data;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       busy;
   logic       done;
   logic       error;
   logic       dev_clk_low;
   logic       dev_dat_low;

   int n_chk;
   int n_bad;
   string g_case;

   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .REQ_CYCLES(REQ),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .CLOCK(clk),
      .reset(reset),
      .send_cmd(send_cmd),
      .cmd_data(cmd_data),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .busy(busy),
      .done(done),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s/%s: got %0h want %0h", g_case, tag, got, exp);
      end
   endtask

   task automatic do_send(input logic [7:0] b);
      @(negedge clk);
      send_cmd = 1'b1;
      cmd_data = b;
      @(negedge clk);
      send_cmd = 1'b0;
   endtask

   task automatic host_phase(input int inj, output int nclk, output int ndat);
      nclk = 0;
      ndat = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!ps2_clk_oe) break;
         nclk++;
         if (ps2_dat_oe) ndat++;
         send_cmd = (nclk == inj);
         if (nclk == inj) cmd_data = 8'h12;
         @(negedge clk);
      end
      send_cmd = 1'b0;
   endtask

   task automatic dev_frame(input logic ack_low, output logic [9:0] bits,
                            output int pulse_at, output int nd, output int ne);
      bits = '0;
      pulse_at = -1;
      nd = 0;
      ne = 0;
      for (int k = 0; k < 10; k++) begin
         repeat (HP) @(negedge clk);
         bits[k] = ps2_dat_in;
         dev_clk_low = 1'b1;
         repeat (HP) @(negedge clk);
         dev_clk_low = 1'b0;
      end
      dev_dat_low = ack_low;
      repeat (HP) @(negedge clk);
      dev_clk_low = 1'b1;
      for (int j = 1; j <= HP; j++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            pulse_at = j;
         end
         if (error) begin
            ne++;
            pulse_at = j;
         end
      end
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
   endtask

   task automatic run_send(input logic [7:0] b, input logic [9:0] exp_bits,
                           input logic ack_low, input int inj);
      int nclk;
      int ndat;
      int pulse_at;
      int nd;
      int ne;
      logic [9:0] bits;
      do_send(b);
      chk("acc_busy", 32'(busy), 1);
      chk("acc_clkoe", 32'(ps2_clk_oe), 1);
      host_phase(inj, nclk, ndat);
      chk("clk_hold", nclk, INH + REQ);
      chk("dat_hold", ndat, REQ);
      dev_frame(ack_low, bits, pulse_at, nd, ne);
      chk("bits", 32'(bits), 32'(exp_bits));
      chk("pulse_at", pulse_at, 3);
      chk("n_done", nd, ack_low ? 1 : 0);
      chk("n_err", ne, ack_low ? 0 : 1);
      chk("idle", 32'({busy, ps2_clk_oe, ps2_dat_oe}), 0);
   endtask

   initial begin
      int nclk;
      int ndat;
      int n;
      n_chk = 0;
      n_bad = 0;
      g_case = "reset";
      reset = 1'b1;
      send_cmd = 1'b0;
      cmd_data = 8'h00;
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outs", 32'({ps2_clk_oe, ps2_dat_oe, busy, done, error}), 0);
      reset = 1'b0;
      @(negedge clk);

      // data LSB first, parity, stop
      g_case = "f4";
      run_send(8'hF4, 10'h2F4, 1'b1, -1);
      g_case = "ff";
      run_send(8'hFF, 10'h3FF, 1'b1, -1);
      g_case = "00";
      run_send(8'h00, 10'h300, 1'b1, -1);
      g_case = "nack";
      run_send(8'hF4, 10'h2F4, 1'b0, -1);

      g_case = "timeout";
      do_send(8'hA5);
      host_phase(-1, nclk, ndat);
      chk("to_err0", 32'(error), 0);
      n = 0;
      while (!error && n < TO + 50) begin
         @(negedge clk);
         n++;
      end
      chk("to_lat", n, TO + 1);
      @(negedge clk);
      chk("to_idle", 32'({busy, ps2_clk_oe, ps2_dat_oe, error}), 0);

      g_case = "async_rst";
      do_send(8'hF4);
      host_phase(-1, nclk, ndat);
      for (int k = 0; k < 3; k++) begin
         repeat (HP) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (HP) @(negedge clk);
         dev_clk_low = 1'b0;
      end
      repeat (6) @(negedge clk);
      chk("pre_rst", 32'({busy, ps2_dat_oe}), 3);
      #2 reset = 1'b1;
      #1;
      chk("rst_lines", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 0);
      @(negedge clk);
      chk("rst_pulse", 32'({done, error}), 0);
      reset = 1'b0;
      @(negedge clk);
      g_case = "after_rst";
      run_send(8'hF4, 10'h2F4, 1'b1, -1);

      g_case = "busy_drop";
      run_send(8'hF4, 10'h2F4, 1'b1, 5);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy || ps2_clk_oe) n++;
      end
      chk("dropped", n, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
